risc_loader: RTL and testbench

Bus-side initiator for the `Risc` core's boot/write port. It accepts a program as a valid/ready word stream and writes it into `Risc` instruction memory at consecutive addresses from 0. It then pulses boot to reset the core's PC, releases the core to run, and captures `io_out` when `io_valid` fires. The result, or a timeout flag, is returned through a valid/ready result port. It sits between the host/test fabric and a `Risc` instance, driving `io_boot`, `io_isWr`, `io_wrAddr` and `io_wrData`, and observing `io_out` and `io_valid`.

---
 rtl/risc_loader.sv | 143 ++++++++++++++
 tb/tb_risc_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_loader.sv
// risc_loader: streams a program into Risc instruction memory, boots the core,
// then waits for io_valid (or a timeout) and returns the result on a valid/ready port.
// Ports:
//   clock, reset                 clock and async active-high reset
//   start, prog_len              job request (sampled in IDLE only)
//   in_valid/in_ready/in_data    program word stream
//   risc_boot/isWr/wrAddr/wrData drive Risc boot/write port
//   risc_out/risc_valid          observe Risc result
//   res_valid/res_ready/res_data/res_timeout  result port
//   busy                         high whenever not IDLE
module risc_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              risc_boot,
  output logic              risc_isWr,
  output logic [ADDR_W-1:0] risc_wrAddr,
  output logic [DATA_W-1:0] risc_wrData,
  input  logic [DATA_W-1:0] risc_out,
  input  logic              risc_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BOOT,
    S_RUN,
    S_RESULT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_boot_ph;
  logic [TO_W-1:0]   r_tcnt;
  logic              r_isWr;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_timeout;

  logic [CNT_W-1:0]  w_len;
  logic              w_last;

  // Oversized lengths are clamped to the full instruction memory
  assign w_len  = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign w_last = (r_cnt == (r_len - CNT_W'(1)));

  // Job sequencer: load, boot, run, report
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_cnt         <= '0;
      r_boot_ph     <= 1'b0;
      r_tcnt        <= '0;
      r_isWr        <= 1'b0;
      r_wrAddr      <= '0;
      r_wrData      <= '0;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      // A write strobe lasts exactly one cycle after its accept
      r_isWr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= w_len;
            r_cnt     <= '0;
            r_boot_ph <= 1'b0;
            r_state   <= (w_len == '0) ? S_BOOT : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_isWr   <= 1'b1;
            r_wrAddr <= r_cnt[ADDR_W-1:0];
            r_wrData <= in_data;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_boot_ph <= 1'b0;
              r_state   <= S_BOOT;
            end
          end
        end
        S_BOOT: begin
          // Second boot cycle is write-free so the core resets its PC cleanly
          if (r_boot_ph) begin
            r_tcnt  <= '0;
            r_state <= S_RUN;
          end else begin
            r_boot_ph <= 1'b1;
          end
        end
        S_RUN: begin
          r_tcnt <= r_tcnt + TO_W'(1);
          if (risc_valid) begin
            r_res_data    <= risc_out;
            r_res_timeout <= 1'b0;
            r_state       <= S_RESULT;
          end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_state       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake/status outputs decode straight from the state register
  assign in_ready    = (r_state == S_LOAD);
  assign risc_boot   = (r_state != S_RUN);
  assign res_valid   = (r_state == S_RESULT);
  assign busy        = (r_state != S_IDLE);
  assign risc_isWr   = r_isWr;
  assign risc_wrAddr = r_wrAddr;
  assign risc_wrData = r_wrData;
  assign res_data    = r_res_data;
  assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_risc_loader.sv
// Scoreboard bench for risc_loader: expected writes/results are queued when
// stimulus is issued; monitor and core-model processes compare at negedge.
module tb_risc_loader;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  prog_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        risc_boot, risc_isWr;
  logic [7:0]  risc_wrAddr;
  logic [31:0] risc_wrData;
  logic [31:0] risc_out = '0;
  logic        risc_valid = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        busy;

  risc_loader #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .risc_boot(risc_boot), .risc_isWr(risc_isWr), .risc_wrAddr(risc_wrAddr),
    .risc_wrData(risc_wrData), .risc_out(risc_out), .risc_valid(risc_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] wr_q[$];   // {addr, data}
  logic [32:0] res_q[$];  // {timeout, data}
  logic [31:0] prog [0:299];

  int          cur_vc  = 0;   // RUN cycle (1-based) in which the core reports; 0 = never
  logic [31:0] cur_out = '0;
  int          exp_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_boot"},     risc_boot, 1);
    chk({tag, "_iswr"},     risc_isWr, 0);
    chk({tag, "_wraddr"},   risc_wrAddr, 0);
    chk({tag, "_wrdata"},   risc_wrData, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_to"},   res_timeout, 0);
    chk({tag, "_busy"},     busy, 0);
  endtask

  // Monitor: writes and results against the scoreboard queues
  always @(negedge clock) begin
    if (!reset) begin
      if (risc_isWr) begin
        if (wr_q.size() == 0) chk("spurious_write", {risc_wrAddr, risc_wrData}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("write_addr_data", {risc_wrAddr, risc_wrData}, wr_q[0]);
          void'(wr_q.pop_front());
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) chk("spurious_result", {res_timeout, res_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("result", {res_timeout, res_data}, res_q[0]);
          if (res_ready) void'(res_q.pop_front());
        end
      end
    end
  end

  // Core model: counts boot/run cycles and raises risc_valid on the chosen RUN cycle
  int run_cnt = 0, boot_cnt = 0;
  bit in_run = 0;
  always @(negedge clock) begin
    if (reset || !busy) begin
      run_cnt = 0; boot_cnt = 0; in_run = 0;
      risc_valid = 1'($urandom_range(0, 1));
      risc_out   = $urandom;
    end else if (!risc_boot) begin
      if (!in_run) begin
        in_run = 1;
        chk("boot_cycles", 64'(boot_cnt), 2);
        chk("writes_before_run", 64'(wr_q.size()), 0);
      end
      run_cnt++;
      risc_valid = (run_cnt == cur_vc);
      risc_out   = risc_valid ? cur_out : $urandom;
    end else if (res_valid) begin
      if (in_run) begin
        in_run = 0;
        chk("run_cycles", 64'(run_cnt), 64'(exp_run));
      end
      risc_valid = 1'($urandom_range(0, 1));
      risc_out   = $urandom;
    end else begin
      if (!in_ready) boot_cnt++;
      risc_valid = 1'($urandom_range(0, 1));
      risc_out   = $urandom;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    @(negedge clock);
    reset = 1'b0;
    wr_q.delete();
    res_q.delete();
  endtask

  task automatic start_job(input int len);
    in_valid = 1'b0;
    @(negedge clock);
    chk("idle_before_start", busy, 0);
    start = 1'b1;
    prog_len = 9'(len);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, (len != 0) ? 1 : 0);
  endtask

  // Stream n words; mode 0 back-to-back, 1 toggling, 2 random gaps
  task automatic feed(input int n, input int mode);
    int idx = 0, cyc = 0;
    bit v, rdy, tog = 0;
    while (idx < n && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      rdy = in_ready;
      chk("in_ready_load", rdy, 1);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? !tog : 1'($urandom_range(0, 1));
      tog = !tog;
      in_valid = v;
      in_data  = prog[idx];
      @(posedge clock);
      if (v && rdy) begin
        wr_q.push_back({8'(idx), prog[idx]});
        idx++;
      end
    end
    if (idx < n) chk("feed_timeout", 64'(idx), 64'(n));
    #1 in_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input int mode, input int vc,
                         input logic [31:0] out, input int rd, input bit start_in_run);
    int n = (len > 256) ? 256 : len;
    int k;
    cur_vc  = vc;
    cur_out = out;
    if (vc >= 1 && vc <= TO) begin
      exp_run = vc;
      res_q.push_back({1'b0, out});
    end else begin
      exp_run = TO;
      res_q.push_back({1'b1, 32'h0});
    end
    start_job(len);
    feed(n, mode);
    if (start_in_run) begin
      k = 0;
      while (risc_boot && k < 50) begin @(negedge clock); k++; end
      if (risc_boot) chk("run_wait", 0, 1);
      start = 1'b1; prog_len = 9'd5;
      repeat (2) @(negedge clock);
      start = 1'b0;
    end
    // Wait for result while driving ignored garbage on the program port
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clock);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      k++;
    end
    in_valid = 1'b0;
    if (!res_valid) begin
      chk("res_valid_wait", 0, 1);
      do_reset();
      return;
    end
    repeat (rd) @(negedge clock);
    @(posedge clock);
    #1 res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    chk("busy_after_accept", busy, 0);
    chk("res_valid_after_accept", res_valid, 0);
    chk("res_q_drained", 64'(res_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 300; i++) prog[i] = $urandom;
    #3;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;

    // 3 words back-to-back
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33;
    run_job(3, 0, 3, $urandom, 0, 0);
    // Gapped stream, result held for 4 cycles
    run_job(3, 1, 5, 32'hDEADBEEF, 4, 0);
    // Timeout, and core reporting on the last RUN cycle
    run_job(7, 2, 0, $urandom, 2, 0);
    run_job(4, 0, TO, 32'hCAFEF00D, 1, 0);
    run_job(2, 0, TO + 1, $urandom, 0, 0);
    // Re-run resident program, full memory, clamped length
    run_job(0, 0, 1, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 300; i++) prog[i] = $urandom;
    run_job(256, 0, 7, $urandom, 0, 0);
    run_job(300, 2, 2, $urandom, 1, 0);
    // start during RUN is ignored
    run_job(6, 2, 5, $urandom, 3, 1);

    // Async reset mid-load after 2 of 5 words
    start_job(5);
    feed(2, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("midload_reset");
    chk("midload_wr_q", 64'(wr_q.size()), 0);
    @(negedge clock);
    reset = 1'b0;
    prog[0] = $urandom;
    run_job(1, 0, 4, $urandom, 0, 0);

    // Random jobs
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 300; i++) prog[i] = $urandom;
      run_job($urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, TO + 2),
              $urandom, $urandom_range(0, 3), 0);
    end

    repeat (3) @(negedge clock);
    chk("final_wr_q_empty", 64'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
